// File: rtl/fetch_sequencer.sv
// Instruction fetch/execute sequencer: owns the PC, fetches 1- or 2-byte
// instructions plus an optional operand byte over a byte-wide req/ack port,
// then hands the instruction to execute and applies branch/halt on completion.
// Ports: clk_i/rst_i (async active-high); mem_req_o/mem_addr_o/mem_ack_i/
// mem_rdata_i memory port; inst_o/data_o/dec_en_o decoder side with
// dec_operand_rd_i/operand_addr_i; exec_valid_o/exec_done_i/take_branch_i/
// branch_target_i/halt_i execute side; pc_o, halted_o status.
// Optional feature macro: SEQ_SINGLE_STEP_EN adds step_i and a STEP_WAIT
// state that parks the sequencer after every completed instruction.
module fetch_sequencer #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        mem_req_o,
    output logic [15:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [7:0]  mem_rdata_i,
    output logic [15:0] inst_o,
    output logic [7:0]  data_o,
    output logic        dec_en_o,
    input  logic        dec_operand_rd_i,
    input  logic [15:0] operand_addr_i,
    output logic        exec_valid_o,
    input  logic        exec_done_i,
    input  logic        take_branch_i,
    input  logic [15:0] branch_target_i,
    input  logic        halt_i,
    output logic [15:0] pc_o,
    output logic        halted_o
`ifdef SEQ_SINGLE_STEP_EN
    ,
    input  logic        step_i
`endif
);

    typedef enum logic [2:0] {
        S_START,
        S_FETCH_HI,
        S_FETCH_LO,
        S_OPERAND,
        S_EXECUTE,
        S_HALTED
`ifdef SEQ_SINGLE_STEP_EN
        ,
        S_STEP_WAIT
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] inst_q, inst_d;
    logic [7:0]  data_q, data_d;
    logic        dec_en_q, exec_valid_q, halted_q;
    logic [15:0] pc_inc;

    // 16-bit add wraps naturally, so an instruction may straddle FFFF->0000.
    assign pc_inc = pc_q + 16'd1;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        data_d  = data_q;
        case (state_q)
            S_START: state_d = S_FETCH_HI;
            S_FETCH_HI: begin
                if (mem_ack_i) begin
                    inst_d  = {mem_rdata_i, 8'h00};
                    pc_d    = pc_inc;
                    // Opcode bit 7 marks a 2-byte instruction.
                    state_d = mem_rdata_i[7] ? S_FETCH_LO : S_OPERAND;
                end
            end
            S_FETCH_LO: begin
                if (mem_ack_i) begin
                    inst_d[7:0] = mem_rdata_i;
                    pc_d        = pc_inc;
                    state_d     = S_OPERAND;
                end
            end
            S_OPERAND: begin
                if (dec_operand_rd_i) begin
                    if (mem_ack_i) begin
                        data_d  = mem_rdata_i;
                        state_d = S_EXECUTE;
                    end
                end else begin
                    state_d = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                if (exec_done_i) begin
                    if (halt_i) begin
                        // halt outranks take_branch; pc is left untouched.
                        state_d = S_HALTED;
                    end else begin
                        if (take_branch_i) begin
                            pc_d = branch_target_i;
                        end
`ifdef SEQ_SINGLE_STEP_EN
                        state_d = S_STEP_WAIT;
`else
                        state_d = S_FETCH_HI;
`endif
                    end
                end
            end
            S_HALTED: state_d = S_HALTED;
`ifdef SEQ_SINGLE_STEP_EN
            S_STEP_WAIT: begin
                if (step_i) begin
                    state_d = S_FETCH_HI;
                end
            end
`endif
            default: state_d = S_START;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_START;
            pc_q         <= RESET_PC;
            inst_q       <= 16'h0000;
            data_q       <= 8'h00;
            dec_en_q     <= 1'b0;
            exec_valid_q <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            data_q       <= data_d;
            // Status flags are registered from the next state so they line up
            // exactly with the state they describe.
            dec_en_q     <= (state_d == S_OPERAND) || (state_d == S_EXECUTE);
            exec_valid_q <= (state_d == S_EXECUTE);
            halted_q     <= (state_d == S_HALTED);
        end
    end

    // Request is decoded from the state register only (plus the decoder's
    // operand flag), never from mem_ack_i, and drops as soon as reset hits.
    always_comb begin
        mem_req_o  = 1'b0;
        mem_addr_o = pc_q;
        case (state_q)
            S_FETCH_HI, S_FETCH_LO: mem_req_o = 1'b1;
            S_OPERAND: begin
                mem_req_o  = dec_operand_rd_i;
                mem_addr_o = operand_addr_i;
            end
            default: mem_req_o = 1'b0;
        endcase
    end

    assign inst_o       = inst_q;
    assign data_o       = data_q;
    assign pc_o         = pc_q;
    assign dec_en_o     = dec_en_q;
    assign exec_valid_o = exec_valid_q;
    assign halted_o     = halted_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_a = 1'b1;
    logic        rst_b = 1'b1;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_rdata = 8'h00;
    logic        dec_operand_rd = 1'b0;
    logic [15:0] operand_addr = 16'h0000;
    logic        exec_done = 1'b0;
    logic        take_branch = 1'b0;
    logic [15:0] branch_target = 16'h0000;
    logic        halt = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
    logic        step = 1'b0;
`endif

    logic        a_req, b_req, a_dec, b_dec, a_ev, b_ev, a_hlt, b_hlt;
    logic [15:0] a_addr, b_addr, a_inst, b_inst, a_pc, b_pc;
    logic [7:0]  a_data, b_data;

    always #5 clk = ~clk;

    fetch_sequencer #(.RESET_PC(16'h0000)) dut_a (
        .clk_i(clk), .rst_i(rst_a),
        .mem_req_o(a_req), .mem_addr_o(a_addr),
        .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata),
        .inst_o(a_inst), .data_o(a_data), .dec_en_o(a_dec),
        .dec_operand_rd_i(dec_operand_rd), .operand_addr_i(operand_addr),
        .exec_valid_o(a_ev), .exec_done_i(exec_done),
        .take_branch_i(take_branch), .branch_target_i(branch_target),
        .halt_i(halt), .pc_o(a_pc), .halted_o(a_hlt)
`ifdef SEQ_SINGLE_STEP_EN
        , .step_i(step)
`endif
    );

    fetch_sequencer #(.RESET_PC(16'hFFFF)) dut_b (
        .clk_i(clk), .rst_i(rst_b),
        .mem_req_o(b_req), .mem_addr_o(b_addr),
        .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata),
        .inst_o(b_inst), .data_o(b_data), .dec_en_o(b_dec),
        .dec_operand_rd_i(dec_operand_rd), .operand_addr_i(operand_addr),
        .exec_valid_o(b_ev), .exec_done_i(exec_done),
        .take_branch_i(take_branch), .branch_target_i(branch_target),
        .halt_i(halt), .pc_o(b_pc), .halted_o(b_hlt)
`ifdef SEQ_SINGLE_STEP_EN
        , .step_i(step)
`endif
    );

    // Select which instance the checks look at.
    logic        sel = 1'b0;
    logic        o_req, o_dec, o_ev, o_hlt;
    logic [15:0] o_addr, o_inst, o_pc;
    logic [7:0]  o_data;
    assign o_req  = sel ? b_req  : a_req;
    assign o_dec  = sel ? b_dec  : a_dec;
    assign o_ev   = sel ? b_ev   : a_ev;
    assign o_hlt  = sel ? b_hlt  : a_hlt;
    assign o_addr = sel ? b_addr : a_addr;
    assign o_inst = sel ? b_inst : a_inst;
    assign o_pc   = sel ? b_pc   : a_pc;
    assign o_data = sel ? b_data : a_data;

    typedef struct {
        logic        ack;
        logic [7:0]  rdata;
        logic        oprd;
        logic [15:0] opaddr;
        logic        done;
        logic        br;
        logic [15:0] tgt;
        logic        hlt;
        logic        e_req;
        logic [15:0] e_addr;
        logic [15:0] e_inst;
        logic [7:0]  e_data;
        logic        e_dec;
        logic        e_ev;
        logic [15:0] e_pc;
        logic        e_halted;
    } vec_t;

    int checks = 0;
    int failures = 0;

    function automatic vec_t mk(
        input logic ack, input logic [7:0] rd, input logic oprd, input logic [15:0] opa,
        input logic done, input logic br, input logic [15:0] tgt, input logic hl,
        input logic req, input logic [15:0] addr, input logic [15:0] inst, input logic [7:0] dat,
        input logic dec, input logic ev, input logic [15:0] pc, input logic hd);
        vec_t v;
        v.ack = ack; v.rdata = rd; v.oprd = oprd; v.opaddr = opa;
        v.done = done; v.br = br; v.tgt = tgt; v.hlt = hl;
        v.e_req = req; v.e_addr = addr; v.e_inst = inst; v.e_data = dat;
        v.e_dec = dec; v.e_ev = ev; v.e_pc = pc; v.e_halted = hd;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d got=%h want=%h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        mem_ack        = v.ack;
        mem_rdata      = v.rdata;
        dec_operand_rd = v.oprd;
        operand_addr   = v.opaddr;
        exec_done      = v.done;
        take_branch    = v.br;
        branch_target  = v.tgt;
        halt           = v.hlt;
    endtask

    task automatic check(input vec_t v, input int idx);
        chk("mem_req", idx, {15'd0, o_req}, {15'd0, v.e_req});
        if (v.e_req) chk("mem_addr", idx, o_addr, v.e_addr);
        chk("inst", idx, o_inst, v.e_inst);
        chk("data", idx, {8'd0, o_data}, {8'd0, v.e_data});
        chk("dec_en", idx, {15'd0, o_dec}, {15'd0, v.e_dec});
        chk("exec_valid", idx, {15'd0, o_ev}, {15'd0, v.e_ev});
        chk("pc", idx, o_pc, v.e_pc);
        chk("halted", idx, {15'd0, o_hlt}, {15'd0, v.e_halted});
    endtask

    task automatic cycle(input vec_t v, input int idx);
        @(posedge clk);
        #1;
        drive(v);
        @(negedge clk);
        check(v, idx);
    endtask

    vec_t tbl[$];
    vec_t seq[$];
    vec_t z;

    initial begin
        z = mk(0,8'h00,0,16'h0,0,0,16'h0,0, 0,16'h0,16'h0,8'h00,0,0,16'h0,0);

        // -- DUT A (RESET_PC=0000): zero-wait 1-byte, waited 2-byte, operand read, branch, halt
        // ack  rd  oprd opaddr done br tgt hlt | req addr inst data dec ev pc halted
        tbl.push_back(mk(1,8'h00,0,16'h0,1,0,16'h0,0, 1,16'h0000,16'h0000,8'h00,0,0,16'h0000,0));
        tbl.push_back(mk(0,8'h00,0,16'h0,1,0,16'h0,0, 0,16'h0000,16'h0000,8'h00,1,0,16'h0001,0));
        tbl.push_back(mk(1,8'hAB,0,16'h0,1,0,16'h0,0, 0,16'h0000,16'h0000,8'h00,1,1,16'h0001,0));
        tbl.push_back(mk(1,8'h00,0,16'h0,1,0,16'h0,0, 1,16'h0001,16'h0000,8'h00,0,0,16'h0001,0));
        tbl.push_back(mk(0,8'h00,0,16'h0,1,0,16'h0,0, 0,16'h0000,16'h0000,8'h00,1,0,16'h0002,0));
        tbl.push_back(mk(0,8'h00,0,16'h0,1,0,16'h0,0, 0,16'h0000,16'h0000,8'h00,1,1,16'h0002,0));
        tbl.push_back(mk(1,8'h00,0,16'h0,1,0,16'h0,0, 1,16'h0002,16'h0000,8'h00,0,0,16'h0002,0));
        tbl.push_back(mk(0,8'h00,0,16'h0,1,0,16'h0,0, 0,16'h0000,16'h0000,8'h00,1,0,16'h0003,0));
        tbl.push_back(mk(0,8'h00,0,16'h0,1,0,16'h0,0, 0,16'h0000,16'h0000,8'h00,1,1,16'h0003,0));
        // 0x88 0x05, two wait cycles per ack
        tbl.push_back(mk(0,8'h00,0,16'h0,0,0,16'h0,0, 1,16'h0003,16'h0000,8'h00,0,0,16'h0003,0));
        tbl.push_back(mk(0,8'h00,0,16'h0,0,0,16'h0,0, 1,16'h0003,16'h0000,8'h00,0,0,16'h0003,0));
        tbl.push_back(mk(1,8'h88,0,16'h0,0,0,16'h0,0, 1,16'h0003,16'h0000,8'h00,0,0,16'h0003,0));
        tbl.push_back(mk(0,8'h00,0,16'h0,0,0,16'h0,0, 1,16'h0004,16'h8800,8'h00,0,0,16'h0004,0));
        tbl.push_back(mk(0,8'h00,0,16'h0,0,0,16'h0,0, 1,16'h0004,16'h8800,8'h00,0,0,16'h0004,0));
        tbl.push_back(mk(1,8'h05,0,16'h0,0,0,16'h0,0, 1,16'h0004,16'h8800,8'h00,0,0,16'h0004,0));
        tbl.push_back(mk(0,8'h00,0,16'h0,0,0,16'h0,0, 0,16'h0000,16'h8805,8'h00,1,0,16'h0005,0));
        tbl.push_back(mk(0,8'h00,0,16'h0,0,0,16'h0,0, 0,16'h0000,16'h8805,8'h00,1,1,16'h0005,0));
        tbl.push_back(mk(0,8'h00,0,16'h0,1,0,16'h0,0, 0,16'h0000,16'h8805,8'h00,1,1,16'h0005,0));
        // 0x84 0x10 with operand read at 1234, then branch to 0100
        tbl.push_back(mk(1,8'h84,0,16'h0,0,0,16'h0,0, 1,16'h0005,16'h8805,8'h00,0,0,16'h0005,0));
        tbl.push_back(mk(1,8'h10,0,16'h0,0,0,16'h0,0, 1,16'h0006,16'h8400,8'h00,0,0,16'h0006,0));
        tbl.push_back(mk(1,8'h5A,1,16'h1234,0,0,16'h0,0, 1,16'h1234,16'h8410,8'h00,1,0,16'h0007,0));
        tbl.push_back(mk(0,8'h00,0,16'h0,1,1,16'h0100,0, 0,16'h0000,16'h8410,8'h5A,1,1,16'h0007,0));
        tbl.push_back(mk(1,8'h01,0,16'h0,0,0,16'h0,0, 1,16'h0100,16'h8410,8'h5A,0,0,16'h0100,0));
        // stray ack while no request must not touch data
        tbl.push_back(mk(1,8'hFF,0,16'h0,0,0,16'h0,0, 0,16'h0000,16'h0100,8'h5A,1,0,16'h0101,0));
        tbl.push_back(mk(0,8'h00,0,16'h0,1,1,16'h0200,1, 0,16'h0000,16'h0100,8'h5A,1,1,16'h0101,0));
        tbl.push_back(mk(1,8'h00,0,16'h0,1,1,16'h0200,1, 0,16'h0000,16'h0100,8'h5A,0,0,16'h0101,1));

        sel = 1'b0;
        drive(z);
        repeat (2) @(posedge clk);
        #1 rst_a = 1'b0;
        @(negedge clk);
        check(z, 0);
        for (int i = 0; i < tbl.size(); i++) cycle(tbl[i], i + 1);
        // Halted: stays put for 20 cycles despite ack activity.
        for (int i = 0; i < 20; i++)
            cycle(mk(i[0],8'h80,0,16'h0,1,0,16'h0,0, 0,16'h0000,16'h0100,8'h5A,0,0,16'h0101,1), 100 + i);

        // -- DUT B (RESET_PC=FFFF): straddling fetch, async reset mid FETCH_LO
        rst_a = 1'b1;
        sel = 1'b1;
        @(posedge clk);
        #1 rst_b = 1'b0;
        drive(z);
        @(negedge clk);
        check(mk(0,8'h00,0,16'h0,0,0,16'h0,0, 0,16'h0,16'h0000,8'h00,0,0,16'hFFFF,0), 200);
        cycle(mk(1,8'h81,0,16'h0,0,0,16'h0,0, 1,16'hFFFF,16'h0000,8'h00,0,0,16'hFFFF,0), 201);
        cycle(mk(0,8'h00,0,16'h0,0,0,16'h0,0, 1,16'h0000,16'h8100,8'h00,0,0,16'h0000,0), 202);
        cycle(mk(0,8'h00,0,16'h0,0,0,16'h0,0, 1,16'h0000,16'h8100,8'h00,0,0,16'h0000,0), 203);
        #1 rst_b = 1'b1;
        #1;
        chk("async_rst_req", 204, {15'd0, o_req}, 16'd0);
        chk("async_rst_pc", 204, o_pc, 16'hFFFF);
        chk("async_rst_inst", 204, o_inst, 16'h0000);
        @(posedge clk);
        #1 rst_b = 1'b0;
        drive(z);
        @(negedge clk);
        check(mk(0,8'h00,0,16'h0,0,0,16'h0,0, 0,16'h0,16'h0000,8'h00,0,0,16'hFFFF,0), 205);
        seq.push_back(mk(1,8'h81,0,16'h0,0,0,16'h0,0, 1,16'hFFFF,16'h0000,8'h00,0,0,16'hFFFF,0));
        seq.push_back(mk(1,8'h22,0,16'h0,0,0,16'h0,0, 1,16'h0000,16'h8100,8'h00,0,0,16'h0000,0));
        seq.push_back(mk(0,8'h00,0,16'h0,1,0,16'h0,0, 0,16'h0000,16'h8122,8'h00,1,0,16'h0001,0));
        seq.push_back(mk(0,8'h00,0,16'h0,1,0,16'h0,0, 0,16'h0000,16'h8122,8'h00,1,1,16'h0001,0));
        seq.push_back(mk(0,8'h00,0,16'h0,1,0,16'h0,0, 1,16'h0001,16'h8122,8'h00,0,0,16'h0001,0));
        for (int i = 0; i < seq.size(); i++) cycle(seq[i], 206 + i);

`ifdef SEQ_SINGLE_STEP_EN
        // -- Single step: park in STEP_WAIT until step, fetch resumes after it
        rst_b = 1'b1;
        sel = 1'b0;
        @(posedge clk);
        #1 rst_a = 1'b0;
        drive(z);
        @(negedge clk);
        cycle(mk(1,8'h00,0,16'h0,1,0,16'h0,0, 1,16'h0000,16'h0000,8'h00,0,0,16'h0000,0), 300);
        cycle(mk(0,8'h00,0,16'h0,1,0,16'h0,0, 0,16'h0000,16'h0000,8'h00,1,0,16'h0001,0), 301);
        cycle(mk(0,8'h00,0,16'h0,1,0,16'h0,0, 0,16'h0000,16'h0000,8'h00,1,1,16'h0001,0), 302);
        cycle(mk(1,8'h00,0,16'h0,1,0,16'h0,0, 0,16'h0000,16'h0000,8'h00,0,0,16'h0001,0), 303);
        cycle(mk(1,8'h00,0,16'h0,1,0,16'h0,0, 0,16'h0000,16'h0000,8'h00,0,0,16'h0001,0), 304);
        @(posedge clk);
        #1 step = 1'b1;
        @(negedge clk);
        chk("step_wait_req", 305, {15'd0, o_req}, 16'd0);
        @(posedge clk);
        #1 step = 1'b0;
        @(negedge clk);
        chk("step_resume_req", 306, {15'd0, o_req}, 16'd1);
        chk("step_resume_addr", 306, o_addr, 16'h0001);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction fetch and execute sequencer for the 16-bit CPU core. It owns the program counter and drives the byte-wide memory port through a request/acknowledge handshake. It assembles 1- or 2-byte instructions into the 16-bit instruction register, fetches one data byte when the decoded instruction needs one, and enables the combinational decoder. It then hands each instruction to the execute stage and waits for completion, applying branches or halting as execute directs.

## Interface
- RESET_PC, 16'h0000, program counter value loaded on reset
- clk  input  1  core clock; all state changes on its rising edge
- rst  input  1  asynchronous, active-high reset
- mem_req  output  1  memory read request; held until acknowledged
- mem_addr  output  16  byte address; stable while mem_req=1
- mem_ack  input  1  read complete; mem_rdata valid in the same cycle
- mem_rdata  input  8  read data byte
- inst  output  16  instruction register; the first byte fetched goes to [15:8]; for 1-byte instructions [7:0]=8'h00
- data  output  8  operand data byte register
- dec_en  output  1  decoder enable; high in OPERAND and EXECUTE states
- dec_operand_rd  input  1  decoder reports that the instruction needs a data-byte read
- operand_addr  input  16  address of that data byte, computed by the datapath
- exec_valid  output  1  instruction ready for execute; high throughout EXECUTE
- exec_done  input  1  execute finished; sampled only while exec_valid=1
- take_branch  input  1  qualifies exec_done: load PC from branch_target
- branch_target  input  16  absolute next PC
- halt  input  1  qualifies exec_done: enter HALTED
- pc  output  16  address of the next instruction byte to fetch
- halted  output  1  high in HALTED
- step  input  1  single-step pulse; present only with the configuration macro

## Operation
- States: START, FETCH_HI, FETCH_LO, OPERAND, EXECUTE, HALTED; STEP_WAIT exists only with the configuration macro.
- START: asserts no outputs; moves to FETCH_HI unconditionally after one cycle.
- FETCH_HI: mem_req=1 and mem_addr=pc.
  - On mem_ack: inst[15:8]<=mem_rdata, inst[7:0]<=0, pc<=pc+1.
  - If mem_rdata[7]=1, go to FETCH_LO; otherwise go to OPERAND.
- FETCH_LO: mem_req=1 and mem_addr=pc. On mem_ack: inst[7:0]<=mem_rdata, pc<=pc+1, go to OPERAND.
- OPERAND: dec_en=1.
  - If dec_operand_rd=1: mem_req=1, mem_addr=operand_addr; on mem_ack, data<=mem_rdata and go to EXECUTE.
  - If dec_operand_rd=0: go to EXECUTE next cycle without a memory request.
- EXECUTE: exec_valid=1 and dec_en=1; inst and data are held. On exec_done, priority is halt > take_branch > sequential:
  - halt: go to HALTED.
  - take_branch: pc<=branch_target, go to FETCH_HI.
  - otherwise go to FETCH_HI.
- HALTED: halted=1 and mem_req=0. Only reset leaves this state.
- pc arithmetic is modulo 2^16: 16'hFFFF+1 wraps to 16'h0000. A 2-byte instruction may straddle the wrap.

## Timing
- Reset values: state=START, pc=RESET_PC, inst=0, data=0, mem_req=0, dec_en=0, exec_valid=0, halted=0.
- Reset asserted mid-operation aborts any pending request immediately. mem_req drops asynchronously; no partial instruction is retained.
- mem_req and mem_addr are decoded from registered state, so there is no combinational path from mem_ack to mem_req.
- mem_ack may arrive in the first cycle of mem_req, giving zero wait states. Each wait cycle extends the state by one cycle.
- mem_ack while mem_req=0 is ignored.
- Minimum latency per instruction with zero wait states, exec_done in the first EXECUTE cycle, and no operand read: 1-byte instruction is 3 cycles, 2-byte instruction is 4 cycles. An operand read adds 0 cycles (it replaces the OPERAND pass-through cycle).
- exec_done together with take_branch: the next mem_addr is branch_target in the following cycle.

## Configuration
- SEQ_SINGLE_STEP_EN defined:
  - EXECUTE completion without halt goes to STEP_WAIT instead of FETCH_HI, with the pc update already applied.
  - STEP_WAIT drives no requests and moves to FETCH_HI on the cycle after step=1 is sampled.
  - A step asserted in any other state is ignored.
- SEQ_SINGLE_STEP_EN undefined: the step port and STEP_WAIT state are absent; behaviour is exactly as described above.

## Test plan
- Reset, memory 00 00 00, zero wait, exec_done tied 1 -> mem_addr 0000, 0001, 0002 on cycles 1, 4, 7; inst=16'h0000 each time.
- Byte 0x88 then 0x05 with 2 wait cycles per ack -> inst=16'h8805 after FETCH_LO; pc=0002; exec_valid asserts with dec_operand_rd=0.
- Instruction 0x84,0x10 with dec_operand_rd=1, operand_addr=16'h1234, mem returns 0x5A -> mem_addr=1234 in OPERAND; data=8'h5A while exec_valid=1.
- exec_done with take_branch=1 and branch_target=16'h0100, plus halt test -> next fetch address 0100. With halt=1 and take_branch=1 together -> halted=1 and mem_req stays 0 for 20 cycles.
- RESET_PC=16'hFFFF, 2-byte instruction -> fetch addresses FFFF then 0000; pc=0001 at EXECUTE. Reset pulsed mid-FETCH_LO -> mem_req=0 immediately; refetch restarts at FFFF.
- SEQ_SINGLE_STEP_EN -> sequencer idles in STEP_WAIT, with no mem_req, until the step pulse. Fetch resumes the cycle after step.
